// File: rtl/fir_pkg.sv
// Shared definitions for the reconfigurable FIR: FSM states, width helpers
// and the output saturation helper.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Ceiling log2, usable in parameter and port width expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Accumulator is wide enough that summing MAX_TAPS full-scale products never overflows.
    function automatic int acc_width(input int data_w, input int coef_w, input int max_taps);
        return data_w + coef_w + clog2(max_taps);
    endfunction

    // Clamp a signed value into the representable range of a w-bit signed word.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int unsigned     w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register bank: gated synchronous write, combinational read by tap index.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int COEF_W   = 16,
    parameter int MAX_TAPS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic signed [COEF_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic signed [COEF_W-1:0] rdata_o
);

    logic signed [COEF_W-1:0] mem_q [MAX_TAPS];

    // Coefficient storage; writes to addresses past the last tap are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MAX_TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (int'(waddr_i) < MAX_TAPS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port feeding the MAC multiplier.
    always_comb begin
        rdata_o = '0;
        if (int'(raddr_i) < MAX_TAPS) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/param_reconf_fir.sv
// Time-multiplexed single-MAC FIR with run-time tap count.
// Define RECONF_FIR_SAT_EN to saturate the output; otherwise it wraps.
module param_reconf_fir
    import fir_pkg::*;
#(
    parameter int DATA_W   = 3,
    parameter int COEF_W   = 16,
    parameter int MAX_TAPS = 16,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 0
) (
    input  logic                              iClk_12M,
    input  logic                              iRst,
    input  logic                              iEnSample,
    input  logic signed [DATA_W-1:0]          iFirIn,
    input  logic [fir_pkg::clog2(MAX_TAPS):0] iNumOfCoeff,
    input  logic                              iCoeffUpdate,
    input  logic                              iCoeffWrEn,
    input  logic [fir_pkg::clog2(MAX_TAPS)-1:0] iCoeffAddr,
    input  logic signed [COEF_W-1:0]          iCoeffData,
    output logic signed [OUT_W-1:0]           oFirOut,
    output logic                              oValid,
    output logic                              oBusy,
    output logic                              oOverrun
);

    localparam int IDX_W  = clog2(MAX_TAPS);
    localparam int NUM_W  = IDX_W + 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, MAX_TAPS);

    state_e                    state_q;
    logic signed [DATA_W-1:0]  taps_q [MAX_TAPS];
    logic signed [ACC_W-1:0]   acc_q;
    logic [NUM_W-1:0]          n_q;
    logic [IDX_W-1:0]          k_q;
    logic signed [OUT_W-1:0]   out_q;
    logic                      valid_q;
    logic                      drop_q;
    logic                      ovr_q;

    logic signed [COEF_W-1:0]  coef_d;
    logic signed [PROD_W-1:0]  prod_d;
    logic [NUM_W-1:0]          n_d;
    logic signed [ACC_W-1:0]   shifted_d;
    logic signed [OUT_W-1:0]   fmt_d;
    logic                      busy_d;
    logic                      coef_we_d;

    assign busy_d    = (state_q == MAC) || (state_q == OUT);
    assign coef_we_d = iCoeffUpdate && iCoeffWrEn && (state_q == IDLE);

    fir_coeff_bank #(
        .COEF_W   (COEF_W),
        .MAX_TAPS (MAX_TAPS),
        .ADDR_W   (IDX_W)
    ) u_coeff_bank (
        .clk_i   (iClk_12M),
        .rst_i   (iRst),
        .we_i    (coef_we_d),
        .waddr_i (iCoeffAddr),
        .wdata_i (iCoeffData),
        .raddr_i (k_q),
        .rdata_o (coef_d)
    );

    // Tap-count clamp, product of the current tap, and output formatting.
    always_comb begin
        n_d = iNumOfCoeff;
        if (iNumOfCoeff > NUM_W'(MAX_TAPS)) begin
            n_d = NUM_W'(MAX_TAPS);
        end
        prod_d    = taps_q[k_q] * coef_d;
        shifted_d = acc_q >>> SHIFT;
`ifdef RECONF_FIR_SAT_EN
        fmt_d = OUT_W'(sat_to_width(64'(shifted_d), OUT_W));
`else
        fmt_d = OUT_W'(shifted_d);
`endif
    end

    // Sample FSM: accept and shift, one MAC per clock, then publish the result.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int unsigned i = 0; i < MAX_TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            // Drop is flagged on the edge that sees the strobe and surfaces one clock later.
            drop_q  <= iEnSample && busy_d;
            ovr_q   <= drop_q;
            case (state_q)
                IDLE: begin
                    if (iEnSample) begin
                        taps_q[0] <= iFirIn;
                        for (int unsigned i = 1; i < MAX_TAPS; i++) begin
                            taps_q[i] <= taps_q[i-1];
                        end
                        acc_q   <= '0;
                        n_q     <= n_d;
                        k_q     <= '0;
                        state_q <= (n_d == '0) ? OUT : MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + ACC_W'(prod_d);
                    k_q   <= k_q + IDX_W'(1);
                    if ({1'b0, k_q} == (n_q - NUM_W'(1))) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    out_q   <= fmt_d;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oFirOut  = out_q;
    assign oValid   = valid_q;
    assign oBusy    = busy_d;
    assign oOverrun = ovr_q;

endmodule
